// File: rtl/control_sequencer_if.sv
// Control bus between the instruction sequencer and the fetch/execute datapath.
// The sequencer is the slave side (consumes IR/resume, drives strobes).
interface control_sequencer_if #(
   parameter int DataWidth  = 16,
   parameter int SelectSize = 2
);
   logic [DataWidth-1:0]  ir;
   logic                  resume;
   logic                  pc_ld;
   logic                  pc_inc;
   logic                  ir_ld;
   logic                  mem_rw;
   logic                  mem_en;
   logic [SelectSize-1:0] addr_src;
   logic                  acc_ld;
   logic                  halted;
   logic                  illegal;
   logic [3:0]            state;

   modport slave (
      input  ir, resume,
      output pc_ld, pc_inc, ir_ld, mem_rw, mem_en, addr_src, acc_ld,
             halted, illegal, state
   );

   modport master (
      output ir, resume,
      input  pc_ld, pc_inc, ir_ld, mem_rw, mem_en, addr_src, acc_ld,
             halted, illegal, state
   );
endinterface

// File: rtl/control_sequencer.sv
// Moore-style instruction sequencer: fetch, decode and execute NOP/HALT/JMP/LD/ST.
// Control strobes are registered alongside the state so they always match it.
module control_sequencer #(
   parameter int DataWidth  = 16,
   parameter int SelectSize = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   control_sequencer_if.slave   bus
);

   typedef enum logic [3:0] {
      ST_RST  = 4'd0,
      ST_F1   = 4'd1,
      ST_F2   = 4'd2,
      ST_DEC  = 4'd3,
      ST_LD1  = 4'd4,
      ST_LD2  = 4'd5,
      ST_ST1  = 4'd6,
      ST_JMP1 = 4'd7,
      ST_HLT  = 4'd8
   } state_e;

   typedef struct packed {
      logic                  pc_ld;
      logic                  pc_inc;
      logic                  ir_ld;
      logic                  mem_rw;
      logic                  mem_en;
      logic [SelectSize-1:0] addr_src;
      logic                  acc_ld;
      logic                  halted;
   } ctl_t;

   localparam logic [SelectSize-1:0] AddrPc = {SelectSize{1'b0}};
   localparam logic [SelectSize-1:0] AddrIr = SelectSize'(1);

   localparam ctl_t CtlDefault = '{
      pc_ld:    1'b1,
      pc_inc:   1'b1,
      ir_ld:    1'b1,
      mem_rw:   1'b0,
      mem_en:   1'b1,
      addr_src: AddrPc,
      acc_ld:   1'b1,
      halted:   1'b0
   };

   // Strobe pattern for a given state; unused encodings fall back to defaults.
   function automatic ctl_t decode_ctl(input state_e s);
      ctl_t c;
      c = CtlDefault;
      case (s)
         ST_F1: begin
            c.mem_en   = 1'b0;
            c.mem_rw   = 1'b0;
            c.addr_src = AddrPc;
         end
         ST_F2: begin
            c.mem_en   = 1'b0;
            c.mem_rw   = 1'b0;
            c.addr_src = AddrPc;
            c.ir_ld    = 1'b0;
            c.pc_inc   = 1'b0;
         end
         ST_LD1: begin
            c.mem_en   = 1'b0;
            c.mem_rw   = 1'b0;
            c.addr_src = AddrIr;
         end
         ST_LD2: begin
            c.mem_en   = 1'b0;
            c.mem_rw   = 1'b0;
            c.addr_src = AddrIr;
            c.acc_ld   = 1'b0;
         end
         ST_ST1: begin
            c.mem_en   = 1'b0;
            c.mem_rw   = 1'b1;
            c.addr_src = AddrIr;
         end
         ST_JMP1: begin
            c.pc_ld    = 1'b0;
         end
         ST_HLT: begin
            c.halted   = 1'b1;
         end
         default: begin
            c = CtlDefault;
         end
      endcase
      return c;
   endfunction

   state_e     state_r;
   state_e     state_next_s;
   ctl_t       ctl_r;
   logic       illegal_r;
   logic       illegal_hit_s;
   logic [3:0] opcode_s;

   assign opcode_s = bus.ir[DataWidth-1 -: 4];

   // Next-state selection; opcode is only consulted in DEC, resume only in HLT.
   always_comb begin
      state_next_s  = ST_RST;
      illegal_hit_s = 1'b0;
      case (state_r)
         ST_RST:  state_next_s = ST_F1;
         ST_F1:   state_next_s = ST_F2;
         ST_F2:   state_next_s = ST_DEC;
         ST_DEC: begin
            case (opcode_s)
               4'h0:    state_next_s = ST_F1;
               4'h1:    state_next_s = ST_HLT;
               4'h2:    state_next_s = ST_JMP1;
               4'h3:    state_next_s = ST_LD1;
               4'h4:    state_next_s = ST_ST1;
               default: begin
                  state_next_s  = ST_F1;
                  illegal_hit_s = 1'b1;
               end
            endcase
         end
         ST_LD1:  state_next_s = ST_LD2;
         ST_LD2:  state_next_s = ST_F1;
         ST_ST1:  state_next_s = ST_F1;
         ST_JMP1: state_next_s = ST_F1;
         ST_HLT: begin
            if (!bus.resume) begin
               state_next_s = ST_F1;
            end else begin
               state_next_s = ST_HLT;
            end
         end
         default: state_next_s = ST_RST;
      endcase
   end

   // State, strobes and sticky illegal flag; strobes are decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r   <= ST_RST;
         ctl_r     <= CtlDefault;
         illegal_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         ctl_r     <= decode_ctl(state_next_s);
         illegal_r <= illegal_r | illegal_hit_s;
      end
   end

   assign bus.pc_ld    = ctl_r.pc_ld;
   assign bus.pc_inc   = ctl_r.pc_inc;
   assign bus.ir_ld    = ctl_r.ir_ld;
   assign bus.mem_rw   = ctl_r.mem_rw;
   assign bus.mem_en   = ctl_r.mem_en;
   assign bus.addr_src = ctl_r.addr_src;
   assign bus.acc_ld   = ctl_r.acc_ld;
   assign bus.halted   = ctl_r.halted;
   assign bus.illegal  = illegal_r;
   assign bus.state    = state_r;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed table-driven bench for control_sequencer plus per-instruction timing sequences.
module tb_control_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b0;

   control_sequencer_if #(.DataWidth(16), .SelectSize(2)) bus ();

   control_sequencer #(.DataWidth(16), .SelectSize(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // {pc_ld, pc_inc, ir_ld, mem_rw, mem_en, addr_src[1:0], acc_ld, halted}
   localparam logic [8:0] C_DEF = 9'b1_1_1_0_1_00_1_0;
   localparam logic [8:0] C_F1  = 9'b1_1_1_0_0_00_1_0;
   localparam logic [8:0] C_F2  = 9'b1_0_0_0_0_00_1_0;
   localparam logic [8:0] C_LD1 = 9'b1_1_1_0_0_01_1_0;
   localparam logic [8:0] C_LD2 = 9'b1_1_1_0_0_01_0_0;
   localparam logic [8:0] C_ST1 = 9'b1_1_1_1_0_01_1_0;
   localparam logic [8:0] C_JMP = 9'b0_1_1_0_1_00_1_0;
   localparam logic [8:0] C_HLT = 9'b1_1_1_0_1_00_1_1;

   typedef struct {
      logic        rst;
      logic        res;
      logic [15:0] ir;
      logic [3:0]  st;
      logic [8:0]  ctl;
      logic        ill;
   } vec_t;

   typedef struct {
      logic [15:0] ir;
      int          cycles;
      int          inc_lows;
      int          ld_lows;
   } instr_t;

   vec_t   tbl[$];
   instr_t seqs[$];
   int     passed = 0;
   int     total  = 0;
   int     viol   = 0;

   function automatic void add(input logic rst, input logic res, input logic [15:0] ir,
                               input logic [3:0] st, input logic [8:0] ctl, input logic ill);
      vec_t v;
      v.rst = rst; v.res = res; v.ir = ir; v.st = st; v.ctl = ctl; v.ill = ill;
      tbl.push_back(v);
   endfunction

   function automatic logic [13:0] observe();
      return {bus.state, bus.pc_ld, bus.pc_inc, bus.ir_ld, bus.mem_rw, bus.mem_en,
              bus.addr_src, bus.acc_ld, bus.halted, bus.illegal};
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Structural invariants watched on every cycle: no load+increment, writes only in ST1.
   always @(negedge clk) begin
      if ((!bus.pc_ld && !bus.pc_inc) || (bus.mem_rw && bus.state != 4'd6)) viol++;
   end

   initial begin
      // reset held two cycles, then release into F1
      add(1'b0, 1'b1, 16'h0000, 4'd0, C_DEF, 1'b0);
      add(1'b0, 1'b1, 16'h0000, 4'd0, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h0000, 4'd1, C_F1,  1'b0);
      // NOP, with resume low outside HLT
      add(1'b1, 1'b0, 16'h0000, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b0, 16'h0000, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h0000, 4'd1, C_F1,  1'b0);
      // LD
      add(1'b1, 1'b1, 16'h30A5, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h30A5, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h30A5, 4'd4, C_LD1, 1'b0);
      add(1'b1, 1'b1, 16'h30A5, 4'd5, C_LD2, 1'b0);
      add(1'b1, 1'b1, 16'h30A5, 4'd1, C_F1,  1'b0);
      // ST
      add(1'b1, 1'b1, 16'h4012, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h4012, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h4012, 4'd6, C_ST1, 1'b0);
      add(1'b1, 1'b1, 16'h4012, 4'd1, C_F1,  1'b0);
      // JMP
      add(1'b1, 1'b1, 16'h20C0, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h20C0, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h20C0, 4'd7, C_JMP, 1'b0);
      add(1'b1, 1'b1, 16'h20C0, 4'd1, C_F1,  1'b0);
      // HALT held five cycles, then released by resume
      add(1'b1, 1'b1, 16'h1000, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h1000, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h1000, 4'd8, C_HLT, 1'b0);
      for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 16'h1000, 4'd8, C_HLT, 1'b0);
      add(1'b1, 1'b0, 16'h1000, 4'd1, C_F1,  1'b0);
      // HALT left by reset and resume together: reset wins
      add(1'b1, 1'b1, 16'h1000, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h1000, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h1000, 4'd8, C_HLT, 1'b0);
      add(1'b0, 1'b0, 16'h1000, 4'd0, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h1000, 4'd1, C_F1,  1'b0);
      // illegal opcode, sticky through NOP, cleared by reset in LD1
      add(1'b1, 1'b1, 16'hF000, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'hF000, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'hF000, 4'd1, C_F1,  1'b1);
      add(1'b1, 1'b1, 16'h0000, 4'd2, C_F2,  1'b1);
      add(1'b1, 1'b1, 16'h0000, 4'd3, C_DEF, 1'b1);
      add(1'b1, 1'b1, 16'h0000, 4'd1, C_F1,  1'b1);
      add(1'b1, 1'b1, 16'h30A5, 4'd2, C_F2,  1'b1);
      add(1'b1, 1'b1, 16'h30A5, 4'd3, C_DEF, 1'b1);
      add(1'b1, 1'b1, 16'h30A5, 4'd4, C_LD1, 1'b1);
      add(1'b0, 1'b1, 16'h30A5, 4'd0, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h0000, 4'd1, C_F1,  1'b0);
      // lowest illegal opcode
      add(1'b1, 1'b1, 16'h5000, 4'd2, C_F2,  1'b0);
      add(1'b1, 1'b1, 16'h5000, 4'd3, C_DEF, 1'b0);
      add(1'b1, 1'b1, 16'h5000, 4'd1, C_F1,  1'b1);

      seqs.push_back('{16'h0000, 3, 1, 0});
      seqs.push_back('{16'h4012, 4, 1, 0});
      seqs.push_back('{16'h20C0, 4, 1, 1});
      seqs.push_back('{16'h30A5, 5, 1, 0});

      bus.ir     = 16'h0000;
      bus.resume = 1'b1;
      reset      = 1'b0;
      @(negedge clk);

      foreach (tbl[i]) begin
         reset      = tbl[i].rst;
         bus.resume = tbl[i].res;
         bus.ir     = tbl[i].ir;
         @(posedge clk);
         @(negedge clk);
         total++;
         if (observe() == {tbl[i].st, tbl[i].ctl, tbl[i].ill}) passed++;
         else $display("FAIL row%0d: got state/ctl/ill %h expected %h", i, observe(),
                       {tbl[i].st, tbl[i].ctl, tbl[i].ill});
      end

      // F1-to-F1 instruction length and strobe counts, bounded at 20 cycles
      foreach (seqs[k]) begin
         int n;
         int inc;
         int ld;
         n = 0; inc = 0; ld = 0;
         bus.ir = seqs[k].ir;
         do begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (!bus.pc_inc) inc++;
            if (!bus.pc_ld) ld++;
         end while (bus.state != 4'd1 && n < 20);
         check($sformatf("len_%h", seqs[k].ir), n, seqs[k].cycles);
         check($sformatf("pc_inc_%h", seqs[k].ir), inc, seqs[k].inc_lows);
         check($sformatf("pc_ld_%h", seqs[k].ir), ld, seqs[k].ld_lows);
      end

      check("invariants", viol, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter DataWidth, default 16, IR width.
REQ-002 Parameter SelectSize, default 2, ADDR_Src width.
REQ-003 Clk  input  1  single system clock; all state changes on rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-005 IR  input  DataWidth  instruction register output from the fetch datapath; opcode = IR[15:12].
REQ-006 Resume  input  1  active-low; releases HALT state.
REQ-007 PC_Ld  output  1  active-low PC load; datapath routes IR[7:0] to PC DIn.
REQ-008 PC_Inc  output  1  active-low PC increment.
REQ-009 IR_Ld  output  1  active-low IR load.
REQ-010 MEM_RW  output  1  0 = read, 1 = write; meaningful only while MEM_En = 0.
REQ-011 MEM_En  output  1  active-low memory enable.
REQ-012 ADDR_Src  output  SelectSize  address mux select: 00 = PC, 01 = IR[7:0].
REQ-013 ACC_Ld  output  1  active-low accumulator load from memory data.
REQ-014 Halted  output  1  active-high; 1 while in HLT.
REQ-015 Illegal  output  1  active-high sticky flag; set on undefined opcode.
REQ-016 State  output  4  current state encoding, for debug.

Function
REQ-017 Moore FSM; all control outputs SHALL be decoded from current state only.
REQ-018 States and encodings: RST=0, F1=1, F2=2, DEC=3, LD1=4, LD2=5, ST1=6, JMP1=7, HLT=8.
REQ-019 Default outputs in every state unless listed: PC_Ld=PC_Inc=IR_Ld=MEM_En=ACC_Ld=1, MEM_RW=0, ADDR_Src=00.
REQ-020 F1 outputs: MEM_En=0, MEM_RW=0, ADDR_Src=00.
REQ-021 F2 outputs: as F1, plus IR_Ld=0 and PC_Inc=0.
REQ-022 DEC outputs: defaults; the opcode is taken from IR in this state, and IR is valid at this point.
REQ-023 LD1 outputs: MEM_En=0, MEM_RW=0, ADDR_Src=01.
REQ-024 LD2 outputs: as LD1, plus ACC_Ld=0.
REQ-025 ST1 outputs: MEM_En=0, MEM_RW=1, ADDR_Src=01.
REQ-026 JMP1 outputs: PC_Ld=0.
REQ-027 HLT outputs: defaults, Halted=1.
REQ-028 Transitions: RST->F1; F1->F2; F2->DEC; LD1->LD2; LD2->F1; ST1->F1; JMP1->F1; HLT->F1 if Resume=0, else HLT.
REQ-029 DEC transitions by opcode: 0x0 NOP->F1; 0x1 HALT->HLT; 0x2 JMP->JMP1; 0x3 LD->LD1; 0x4 ST->F1 via ST1 (DEC->ST1).
REQ-030 Opcodes 0x5-0xF in DEC SHALL go DEC->F1 and set Illegal=1 on the same edge.
REQ-031 Illegal SHALL stay set until reset.
REQ-032 Instruction lengths in cycles: NOP 3, HALT 3 plus halt time, JMP 4, ST 4, LD 5.
REQ-033 PC_Inc SHALL assert exactly once per instruction, in F2 only.
REQ-034 JMP therefore overrides the F2 increment, and no state SHALL assert both PC_Ld and PC_Inc.
REQ-035 Resume=0 in any state other than HLT SHALL have no effect.
REQ-036 Unused encodings 9-15 SHALL transition to RST with default outputs.
REQ-037 Write (MEM_RW=1) SHALL occur only in ST1.

Reset
REQ-038 Reset=0 at a rising edge SHALL force the state to RST from any state, including mid-instruction and HLT; Reset has priority over Resume.
REQ-039 In RST all outputs SHALL be at defaults: Halted=0, Illegal=0, State=0.
REQ-040 The first edge with Reset=1 SHALL move RST->F1.
REQ-041 Reset has no asynchronous path.

Verification
REQ-042 Reset low 2 cycles, then high -> State 0 then 1; F1 shows MEM_En=0, MEM_RW=0, ADDR_Src=00, all other controls 1.
REQ-043 IR=0x0000 (NOP) -> sequence F1,F2,DEC,F1; PC_Inc=0 and IR_Ld=0 only in F2.
REQ-044 IR=0x30A5 (LD) -> DEC->LD1->LD2 with ADDR_Src=01; ACC_Ld=0 only in LD2; back to F1 after 5 cycles total.
REQ-045 IR=0x4012 (ST) -> ST1 with MEM_RW=1, MEM_En=0, ADDR_Src=01 for exactly one cycle. IR=0x20C0 (JMP) -> PC_Ld=0 exactly one cycle, PC_Inc=1 in JMP1.
REQ-046 IR=0x1000 (HALT) -> Halted=1; holds 5 cycles with Resume=1; Resume=0 -> next state F1, Halted=0. Repeat with Reset=0 and Resume=0 together in HLT -> RST.
REQ-047 IR=0xF000 -> Illegal=1 after DEC, then F1; Illegal persists through a following NOP; reset asserted in LD1 -> RST, Illegal=0.
